// File: rtl/mc_alu.sv
// Multi-cycle ALU for the MIPS execute stage: registered results, start/done handshake,
// signed overflow, and an iterative shift-add multiplier compiled in when MC_ALU_MUL_EN is defined.
module mc_alu #(
  parameter int WIDTH = 16,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SRL = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             ovf_q;
  logic             done_q;

  logic             is_sub;
  logic             is_mul;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  // Sub reuses the adder as a + ~b + 1; the sign of ~b equals the sign of -b for overflow purposes.
  always_comb begin
    is_sub  = (aluOp == OP_SUB);
    is_mul  = (aluOp == OP_MUL);
    b_eff   = is_sub ? ~b : b;
    sum     = a + b_eff + {{(WIDTH-1){1'b0}}, is_sub};
    add_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    alu_res = '0;
    alu_ovf = 1'b0;
    case (aluOp)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_ADD, OP_SUB: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLL: alu_res = b << shamt;
      OP_SRL: alu_res = b >> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef MC_ALU_MUL_EN
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   hi_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     psum;
  logic               last;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = (start && is_mul) ? S_MUL : S_IDLE;
      S_MUL:   state_d = last ? S_IDLE : S_MUL;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_MUL);
  end

  // Upper half accumulates the multiplicand; lower half holds the multiplier and shifts out LSB first.
  always_comb begin
    psum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    acc_d = {psum, acc_q[WIDTH-1:1]};
    last  = (cnt_q == SHW'(WIDTH-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_mul) begin
              acc_q   <= {{WIDTH{1'b0}}, b};
              mcand_q <= a;
              cnt_q   <= '0;
            end else begin
              out_q  <= alu_res;
              zero_q <= (alu_res == '0);
              ovf_q  <= alu_ovf;
              done_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + SHW'(1);
          if (last) begin
            out_q  <= acc_d[WIDTH-1:0];
            hi_q   <= acc_d[2*WIDTH-1:WIDTH];
            zero_q <= (acc_d[WIDTH-1:0] == '0);
            ovf_q  <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi = hi_q;
`else
  // Without the multiplier every op, including aluOp=011 (result 0), completes in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= '0;
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        out_q  <= alu_res;
        zero_q <= (alu_res == '0);
        ovf_q  <= alu_ovf;
        done_q <= 1'b1;
      end
    end
  end

  assign busy = 1'b0;
  assign hi   = '0;
`endif

  assign out  = out_q;
  assign zero = zero_q;
  assign ovf  = ovf_q;
  assign done = done_q;

endmodule

// File: tb/tb_mc_alu.sv
// Randomized self-checking bench for mc_alu at WIDTH=16 and WIDTH=32 against an arithmetic reference model.
module tb_mc_alu;

`ifdef MC_ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        st;
  logic        sel32;
  logic [2:0]  op_in;
  logic [31:0] a_in, b_in;
  logic [4:0]  sh_in;

  logic [15:0] out16, hi16;
  logic        zero16, ovf16, busy16, done16;
  logic [31:0] out32, hi32;
  logic        zero32, ovf32, busy32, done32;

  logic [31:0] o_out, o_hi;
  logic        o_zero, o_ovf, o_busy, o_done;

  int checks   = 0;
  int failures = 0;
  longint unsigned exp_hi16 = 0;
  longint unsigned exp_hi32 = 0;

  always #5 clk = ~clk;

  mc_alu #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(st & ~sel32), .aluOp(op_in),
    .a(a_in[15:0]), .b(b_in[15:0]), .shamt(sh_in[3:0]),
    .out(out16), .hi(hi16), .zero(zero16), .ovf(ovf16), .busy(busy16), .done(done16)
  );

  mc_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(st & sel32), .aluOp(op_in),
    .a(a_in), .b(b_in), .shamt(sh_in),
    .out(out32), .hi(hi32), .zero(zero32), .ovf(ovf32), .busy(busy32), .done(done32)
  );

  always_comb begin
    o_out  = sel32 ? out32  : {16'h0, out16};
    o_hi   = sel32 ? hi32   : {16'h0, hi16};
    o_zero = sel32 ? zero32 : zero16;
    o_ovf  = sel32 ? ovf32  : ovf16;
    o_busy = sel32 ? busy32 : busy16;
    o_done = sel32 ? done32 : done16;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: operands interpreted as signed/unsigned integers, results reduced to w bits.
  function automatic void ref_op(input int w, input logic [2:0] op,
                                 input longint unsigned ua, input longint unsigned ub, input int sh,
                                 output longint unsigned o, output bit v, output longint unsigned h);
    longint unsigned mask, full;
    longint lim, sa, sb, r;
    mask = (64'd1 << w) - 1;
    lim  = longint'(64'd1 << (w - 1));
    sa   = (ua >= lim) ? longint'(ua) - 2 * lim : longint'(ua);
    sb   = (ub >= lim) ? longint'(ub) - 2 * lim : longint'(ub);
    o = 0; v = 0; h = 0;
    case (op)
      3'b000: o = ua & ub;
      3'b001: o = ua | ub;
      3'b010: begin r = sa + sb; o = longint'(r) & mask; v = (r >= lim) || (r < -lim); end
      3'b110: begin r = sa - sb; o = longint'(r) & mask; v = (r >= lim) || (r < -lim); end
      3'b111: o = (sa < sb) ? 1 : 0;
      3'b100: o = (ub << sh) & mask;
      3'b101: o = ub >> sh;
      default: begin
        full = ua * ub;
        o = MUL_EN ? (full & mask) : 0;
        h = MUL_EN ? (full >> w) : 0;
      end
    endcase
  endfunction

  task automatic run(input bit w32, input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib, input int sh);
    int w, n;
    longint unsigned mask, eo, eh;
    bit ev;
    w = w32 ? 32 : 16;
    mask = (64'd1 << w) - 1;
    ref_op(w, op, ia & mask, ib & mask, sh, eo, ev, eh);
    @(negedge clk);
    sel32 = w32; st = 1'b1; op_in = op; a_in = ia; b_in = ib; sh_in = sh[4:0];
    @(posedge clk); #1;
    st = 1'b0;
    if (op == 3'b011 && MUL_EN) begin
      chk("mul_busy_start", o_busy, 1);
      chk("mul_done_early", o_done, 0);
      n = 0;
      while (!o_done && n < 2 * w + 4) begin
        if (n == 3) begin st = 1'b1; a_in = ~ia; end
        else st = 1'b0;
        @(posedge clk); #1;
        n++;
      end
      st = 1'b0;
      chk("mul_latency", n, w);
      if (w32) exp_hi32 = eh; else exp_hi16 = eh;
    end else begin
      chk("done_pulse", o_done, 1);
    end
    chk("out", o_out, eo);
    chk("zero", o_zero, (eo == 0));
    chk("ovf", o_ovf, ev);
    chk("hi", o_hi, w32 ? exp_hi32 : exp_hi16);
    chk("busy_end", o_busy, 0);
    @(posedge clk); #1;
    chk("done_clear", o_done, 0);
    chk("out_hold", o_out, eo);
  endtask

  function automatic logic [31:0] rnd_val(input int w);
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h1 << (w - 1);
      3: return (32'h1 << (w - 1)) - 1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st = 1'b0; sel32 = 1'b0; op_in = 3'b000; a_in = '0; b_in = '0; sh_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out16", out16, 0);   chk("rst_hi16", hi16, 0);
    chk("rst_zero16", zero16, 0); chk("rst_ovf16", ovf16, 0);
    chk("rst_busy16", busy16, 0); chk("rst_done16", done16, 0);
    chk("rst_out32", out32, 0);   chk("rst_done32", done32, 0);
    @(negedge clk); rst = 1'b0;

    run(0, 3'b010, 32'h7325, 32'h4941, 0);
    chk("s1_out", o_out, 32'hBC66); chk("s1_ovf", o_ovf, 1);
    run(0, 3'b110, 32'h7325, 32'h4941, 0);
    chk("s2_sub", o_out, 32'h29E4);
    run(0, 3'b111, 32'h7325, 32'h4941, 0);
    chk("s2_slt_zero", o_zero, 1);
    run(0, 3'b100, 32'h7325, 32'h5941, 2);
    chk("s3_sll", o_out, 32'h6504);
    run(0, 3'b101, 32'h7325, 32'h5941, 2);
    chk("s3_srl", o_out, 32'h1650);
    run(0, 3'b010, 32'h0, 32'h0, 0);
    chk("s3_zero", o_zero, 1);
    run(0, 3'b011, 32'h0123, 32'h0456, 0);
    chk("s4_out", o_out, MUL_EN ? 32'hEDC2 : 32'h0);
    chk("s4_hi", o_hi, MUL_EN ? 32'h0004 : 32'h0);

    // Reset four cycles into a multiply aborts it and clears all outputs.
    run(0, 3'b010, 32'h7325, 32'h4941, 0);
    @(negedge clk);
    sel32 = 1'b0; st = 1'b1; op_in = 3'b011; a_in = 32'h0123; b_in = 32'h0456;
    @(posedge clk); #1;
    st = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_hi16 = 0; exp_hi32 = 0;
    chk("abort_busy", o_busy, 0); chk("abort_done", o_done, 0);
    chk("abort_out", o_out, 0);   chk("abort_hi", o_hi, 0);
    chk("abort_zero", o_zero, 0); chk("abort_ovf", o_ovf, 0);
    run(0, 3'b010, 32'h1, 32'h1, 0);
    chk("s5_add", o_out, 32'h2);

    // Reset and start at the same edge: reset wins.
    @(negedge clk);
    sel32 = 1'b0; st = 1'b1; op_in = 3'b010; a_in = 32'h5; b_in = 32'h6; rst = 1'b1;
    @(posedge clk); #1;
    st = 1'b0; rst = 1'b0;
    chk("rst_wins_done", o_done, 0);
    chk("rst_wins_out", o_out, 0);

    run(1, 3'b010, 32'h7FFF_FFFF, 32'h1, 0);
    chk("s6_add", o_out, 32'h8000_0000); chk("s6_ovf", o_ovf, 1);
    run(1, 3'b101, 32'h0, 32'h8000_0000, 31);
    chk("s6_srl", o_out, 32'h1);
    run(1, 3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    for (int i = 0; i < 150; i++)
      run(0, 3'($urandom_range(0, 7)), rnd_val(16), rnd_val(16), int'($urandom_range(0, 15)));
    for (int i = 0; i < 60; i++)
      run(1, 3'($urandom_range(0, 7)), rnd_val(32), rnd_val(32), int'($urandom_range(0, 31)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
